// File: rtl/down_count_checker.sv
// -----------------------------------------------------------------------------
// down_count_checker
// Receive-side monitor for a down-counter sequence generator. Every clock it
// samples enable/count and checks that each step either holds (previous
// enable low) or decrements by one modulo 2^N (previous enable high).
// After an initial capture edge it acquires the stream, locks after LOCK_CNT
// consecutive correct steps, and then flags wrong steps as mismatches.
// A correct 0 -> 2^N-1 decrement is reported as a wrap.
//
// Build option:
//   DCHK_ERR_COUNT_EN - when defined, err_count is a saturating mismatch
//                       counter; when undefined, err_count is tied to zero.
// -----------------------------------------------------------------------------
module down_count_checker #(
   parameter int N        = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [N-1:0]     count,
   output logic             locked,
   output logic             mismatch,
   output logic             wrap,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [3:0]   LOCK_RUN = 4'(LOCK_CNT);
   localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
   localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

   state_t         state_r;
   state_t         state_nxt_s;
   logic [N-1:0]   prev_count_r;
   logic           prev_en_r;
   logic [3:0]     run_r;
   logic [3:0]     run_nxt_s;
   logic [N-1:0]   exp_s;
   logic           correct_s;
   logic           wrap_hit_s;
   logic           mismatch_nxt_s;
   logic           wrap_nxt_s;

   // Expected value is a modulo-2^N decrement when the generator was enabled
   assign exp_s      = prev_en_r ? (prev_count_r - CNT_ONE) : prev_count_r;
   assign correct_s  = (count == exp_s);
   assign wrap_hit_s = correct_s && prev_en_r && (prev_count_r == CNT_ZERO);

   // Next-state, run length and event pulses for the acquire/lock FSM
   always_comb begin
      state_nxt_s    = state_r;
      run_nxt_s      = run_r;
      mismatch_nxt_s = 1'b0;
      wrap_nxt_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // capture edge only: the reference is loaded, nothing is checked
            state_nxt_s = ST_ACQUIRE;
            run_nxt_s   = 4'd0;
         end
         ST_ACQUIRE: begin
            if (correct_s) begin
               run_nxt_s  = run_r + 4'd1;
               wrap_nxt_s = wrap_hit_s;
               if ((run_r + 4'd1) >= LOCK_RUN) begin
                  state_nxt_s = ST_LOCKED;
               end else begin
                  state_nxt_s = ST_ACQUIRE;
               end
            end else begin
               // silent restart while still acquiring
               run_nxt_s   = 4'd0;
               state_nxt_s = ST_ACQUIRE;
            end
         end
         ST_LOCKED: begin
            if (correct_s) begin
               state_nxt_s = ST_LOCKED;
               wrap_nxt_s  = wrap_hit_s;
            end else begin
               mismatch_nxt_s = 1'b1;
               run_nxt_s      = 4'd0;
               state_nxt_s    = ST_ACQUIRE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            run_nxt_s   = 4'd0;
         end
      endcase
   end

   // State, reference sample and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         prev_count_r <= CNT_ZERO;
         prev_en_r    <= 1'b0;
         run_r        <= 4'd0;
         locked       <= 1'b0;
         mismatch     <= 1'b0;
         wrap         <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         // the current sample always becomes the new reference, so a wrong
         // value resynchronises the checker onto the new stream position
         prev_count_r <= count;
         prev_en_r    <= enable;
         run_r        <= run_nxt_s;
         locked       <= (state_nxt_s == ST_LOCKED);
         mismatch     <= mismatch_nxt_s;
         wrap         <= wrap_nxt_s;
      end
   end

`ifdef DCHK_ERR_COUNT_EN
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   // Saturating increment: holds at all-ones instead of rolling over
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      if (v == ERR_MAX) begin
         return v;
      end else begin
         return v + ERR_ONE;
      end
   endfunction

   // Mismatch tally, incremented on the same edge that raises mismatch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= {ERR_W{1'b0}};
      end else if (mismatch_nxt_s) begin
         err_count <= sat_inc(err_count);
      end else begin
         err_count <= err_count;
      end
   end
`else
   assign err_count = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_down_count_checker.sv
// -----------------------------------------------------------------------------
// tb_down_count_checker
// Directed bench for down_count_checker (N=4, LOCK_CNT=3). A second instance
// with ERR_W=2 shares the stimulus so that err_count saturation is observed.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_down_count_checker;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] count;
   logic       locked;
   logic       mismatch;
   logic       wrap;
   logic [7:0] err_count;
   logic       locked_s2;
   logic       mismatch_s2;
   logic       wrap_s2;
   logic [1:0] err_count_s2;

   int n_checks;
   int n_pass;

`ifdef DCHK_ERR_COUNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   down_count_checker #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .count(count),
      .locked(locked), .mismatch(mismatch), .wrap(wrap), .err_count(err_count)
   );

   down_count_checker #(.N(4), .LOCK_CNT(3), .ERR_W(2)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .count(count),
      .locked(locked_s2), .mismatch(mismatch_s2), .wrap(wrap_s2),
      .err_count(err_count_s2)
   );

   // 10-unit free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks = n_checks + 1;
      if (got == exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // apply one sample, take one edge, settle past the edge
   task automatic drive(input logic en, input logic [3:0] c);
      enable = en;
      count  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input int lk, input int mm,
                             input int wr, input int err);
      check_val({tag, ".locked"},   int'(locked),    lk);
      check_val({tag, ".mismatch"}, int'(mismatch),  mm);
      check_val({tag, ".wrap"},     int'(wrap),      wr);
      check_val({tag, ".err"},      int'(err_count), ERR_EN ? err : 0);
   endtask

   initial begin
      logic [3:0] c;
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b0;
      enable   = 1'b1;
      count    = 4'd15;
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 0, 0);
      rst = 1'b1;

      // clean run: capture 15, then 14, 13, 12 -> locked after 4th edge
      drive(1'b1, 4'd15); expect_out("cap", 0, 0, 0, 0);
      drive(1'b1, 4'd14); expect_out("acq1", 0, 0, 0, 0);
      drive(1'b1, 4'd13); expect_out("acq2", 0, 0, 0, 0);
      drive(1'b1, 4'd12); expect_out("lock", 1, 0, 0, 0);
      drive(1'b1, 4'd11); expect_out("run11", 1, 0, 0, 0);

      // hold at 9 for 5 cycles, then resume
      drive(1'b1, 4'd10); expect_out("run10", 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'd9); expect_out("hold", 1, 0, 0, 0);
      end
      drive(1'b1, 4'd9); expect_out("resume9", 1, 0, 0, 0);
      drive(1'b1, 4'd8); expect_out("resume8", 1, 0, 0, 0);
      drive(1'b1, 4'd7);
      drive(1'b1, 4'd6); expect_out("run6", 1, 0, 0, 0);

      // injected error: 7 where 5 expected, then re-lock on 6, 5, 4
      drive(1'b1, 4'd7); expect_out("inj", 0, 1, 0, 1);
      drive(1'b1, 4'd6); expect_out("relock1", 0, 0, 0, 1);
      drive(1'b1, 4'd5); expect_out("relock2", 0, 0, 0, 1);
      drive(1'b1, 4'd4); expect_out("relock3", 1, 0, 0, 1);

      // wrap on 0 -> 15 only
      drive(1'b1, 4'd3);
      drive(1'b1, 4'd2);
      drive(1'b1, 4'd1);
      drive(1'b1, 4'd0);  expect_out("pre_wrap", 1, 0, 0, 1);
      drive(1'b1, 4'd15); expect_out("wrap", 1, 0, 1, 1);
      drive(1'b1, 4'd14); expect_out("post_wrap", 1, 0, 0, 1);

      // second mismatch (5 where 13 expected), then a bad value while acquiring
      drive(1'b1, 4'd5); expect_out("inj2", 0, 1, 0, 2);
      drive(1'b1, 4'd4); expect_out("acqA", 0, 0, 0, 2);
      drive(1'b1, 4'd9); expect_out("acq_bad", 0, 0, 0, 2);
      drive(1'b1, 4'd8); expect_out("acqB1", 0, 0, 0, 2);
      drive(1'b1, 4'd7); expect_out("acqB2", 0, 0, 0, 2);
      drive(1'b1, 4'd6); expect_out("acqB3", 1, 0, 0, 2);
      check_val("sat.err2", int'(err_count_s2), ERR_EN ? 2 : 0);

      // asynchronous reset between edges
      #3;
      rst = 1'b0;
      #1;
      expect_out("async_rst", 0, 0, 0, 0);
      check_val("async_rst.err_sat", int'(err_count_s2), 0);
      enable = 1'b1;
      count  = 4'd15;
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b1, 4'd15); expect_out("rcap", 0, 0, 0, 0);
      drive(1'b1, 4'd14);
      drive(1'b1, 4'd13); expect_out("racq", 0, 0, 0, 0);
      drive(1'b1, 4'd12); expect_out("rlock", 1, 0, 0, 0);

      // saturation: five lock/mismatch cycles
      c = 4'd12;
      for (int k = 0; k < 5; k++) begin
         c = c + 4'd2;
         drive(1'b1, c);
         check_val("sat.mismatch", int'(mismatch), 1);
         check_val("sat.err8", int'(err_count), ERR_EN ? (k + 1) : 0);
         check_val("sat.err2", int'(err_count_s2), ERR_EN ? ((k < 3) ? (k + 1) : 3) : 0);
         for (int j = 0; j < 3; j++) begin
            c = c - 4'd1;
            drive(1'b1, c);
         end
         check_val("sat.relock", int'(locked), 1);
      end
      check_val("sat.final", int'(err_count_s2), ERR_EN ? 3 : 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
